// File: rtl/z80_vram_arbiter.sv
// Arbiter sharing one single-port synchronous VRAM between a zero-wait-state Z80
// wrapper and the video fetcher; the CPU always wins, video takes the remaining cycles.
module z80_vram_arbiter #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_in,
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_adr,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    output logic [AW-1:0] ram_adr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        RTN_NONE = 2'd0,
        RTN_CPU  = 2'd1,
        RTN_VID  = 2'd2
    } rtn_t;

    logic cpu_act_s;
    logic cpu_start_s;
    logic prev_act_r;
    rtn_t grant_s;
    rtn_t rtn_r;

    // A strobe only claims the RAM on its first cycle, however long it is held.
    assign cpu_act_s   = cpu_cs & (cpu_rd | cpu_wr);
    assign cpu_start_s = cpu_act_s & ~prev_act_r;
    assign ram_din     = cpu_din;

    // Grant mux: CPU start first, then video, otherwise idle on the CPU address.
    always_comb begin
        ram_adr = cpu_adr;
        ram_we  = 1'b0;
        vid_ack = 1'b0;
        grant_s = RTN_NONE;
        if (reset_in) begin
            ram_we  = 1'b0;
            vid_ack = 1'b0;
            grant_s = RTN_NONE;
        end else if (cpu_start_s) begin
            ram_we  = cpu_wr;
            // rd+wr together is a write and returns nothing
            grant_s = cpu_wr ? RTN_NONE : RTN_CPU;
        end else if (vid_req) begin
            ram_adr = vid_adr;
            vid_ack = 1'b1;
            grant_s = RTN_VID;
        end else begin
            ram_adr = cpu_adr;
            grant_s = RTN_NONE;
        end
    end

    // Return pipeline: steer RAM data one clock after the grant to its owner.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            prev_act_r <= 1'b1;
            rtn_r      <= RTN_NONE;
            cpu_dout   <= {DW{1'b1}};
            vid_data   <= {DW{1'b0}};
            vid_valid  <= 1'b0;
        end else begin
            prev_act_r <= cpu_act_s;
            rtn_r      <= grant_s;
            case (rtn_r)
                RTN_CPU: begin
                    cpu_dout  <= ram_dout;
                    vid_valid <= 1'b0;
                end
                RTN_VID: begin
                    vid_data  <= ram_dout;
                    vid_valid <= 1'b1;
                end
                default: begin
                    vid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
